// File: rtl/iob_ethmac_mem_arbiter_pkg.sv
// rtl/iob_ethmac_mem_arbiter_pkg.sv - shared types and sizing helpers for the ethmac memory arbiter
package iob_ethmac_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_N_REQ  = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Byte-strobe width for a given data width
  function automatic int calc_wstrb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Requester index width, never narrower than one bit
  function automatic int calc_idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/iob_ethmac_mem_arbiter_if.sv
// rtl/iob_ethmac_mem_arbiter_if.sv - requester-side and memory-side IOb signals of the arbiter
interface iob_ethmac_mem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]          req_valid_i;
  logic [N_REQ*ADDR_W-1:0]   req_addr_i;
  logic [N_REQ*DATA_W-1:0]   req_wdata_i;
  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i;
  logic [DATA_W-1:0]         req_rdata_o;
  logic [N_REQ-1:0]          req_ready_o;

  logic                      m_valid_o;
  logic [ADDR_W-1:0]         m_addr_o;
  logic [DATA_W-1:0]         m_wdata_o;
  logic [DATA_W/8-1:0]       m_wstrb_o;
  logic [DATA_W-1:0]         m_rdata_i;
  logic                      m_ready_i;

  // Arbiter view
  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, m_rdata_i, m_ready_i,
    output req_rdata_o, req_ready_o, m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );

  // Environment view: requesters plus memory
  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, m_rdata_i, m_ready_i,
    input  req_rdata_o, req_ready_o, m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );

endinterface

// File: rtl/iob_ethmac_mem_arbiter_rr_picker.sv
// rtl/iob_ethmac_mem_arbiter_rr_picker.sv - combinational first-valid-from-pointer picker with exclude mask
module iob_ethmac_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [N_REQ-1:0] i_excl,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] w_eff;

  assign w_eff = i_req & ~i_excl;

  // Search upward from the pointer, then wrap and search from index 0
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && w_eff[k] && (k >= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_idx      = IDX_W'(k);
        o_grant[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && w_eff[k]) begin
        o_any      = 1'b1;
        o_idx      = IDX_W'(k);
        o_grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_ethmac_mem_arbiter.sv
// rtl/iob_ethmac_mem_arbiter.sv - N-way IOb memory port arbiter; IOB_ETHMAC_ARB_FIXED_PRIO_EN selects fixed priority
module iob_ethmac_mem_arbiter
  import iob_ethmac_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  iob_ethmac_mem_arbiter_if.slave bus,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int WSTRB_W = calc_wstrb_w(DATA_W);
  localparam int IDX_W   = calc_idx_w(N_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]   r_gidx;
  logic               r_m_valid;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [DATA_W-1:0]  r_m_wdata;
  logic [WSTRB_W-1:0] r_m_wstrb;

  logic               w_done;
  logic               w_load;
  logic               w_clear;
  logic [N_REQ-1:0]   w_excl;
  logic [IDX_W-1:0]   w_ptr;
  logic [N_REQ-1:0]   w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [WSTRB_W-1:0] w_sel_wstrb;

  // The completing requester still holds valid during its ready cycle, so it sits out that round
  assign w_done = (r_state == BUSY) && bus.m_ready_i;
  assign w_excl = w_done ? r_grant : '0;

`ifdef IOB_ETHMAC_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_inc;

  assign w_ptr_inc = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
  assign w_ptr     = w_done ? w_ptr_inc : r_ptr;

  // Round-robin pointer moves past whoever just completed
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr <= '0;
    end else if (w_done) begin
      r_ptr <= w_ptr_inc;
    end
  end
`endif

  iob_ethmac_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (bus.req_valid_i),
    .i_ptr   (w_ptr),
    .i_excl  (w_excl),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Payload mux driven by the one-hot pick
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick_grant[k]) begin
        w_sel_addr  = bus.req_addr_i[k*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata_i[k*DATA_W +: DATA_W];
        w_sel_wstrb = bus.req_wstrb_i[k*WSTRB_W +: WSTRB_W];
      end
    end
  end

  // Next-state logic: load a winner from IDLE, or re-arbitrate on completion
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ready_i) begin
          if (w_pick_any) begin
            w_load = 1'b1;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant and registered memory-side request; payload is frozen at grant
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_wstrb <= '0;
    end else if (w_load) begin
      r_grant   <= w_pick_grant;
      r_gidx    <= w_pick_idx;
      r_m_valid <= 1'b1;
      r_m_addr  <= w_sel_addr;
      r_m_wdata <= w_sel_wdata;
      r_m_wstrb <= w_sel_wstrb;
    end else if (w_clear) begin
      r_grant   <= '0;
      r_m_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o = (r_state == BUSY) ? (r_grant & {N_REQ{bus.m_ready_i}}) : '0;
  assign bus.req_rdata_o = (r_state == BUSY) ? bus.m_rdata_i : '0;
  assign bus.m_valid_o   = r_m_valid;
  assign bus.m_addr_o    = r_m_addr;
  assign bus.m_wdata_o   = r_m_wdata;
  assign bus.m_wstrb_o   = r_m_wstrb;
  assign grant_o         = r_grant;
  assign busy_o          = (r_state == BUSY);

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// tb/tb_iob_ethmac_mem_arbiter.sv - directed self-checking bench for iob_ethmac_mem_arbiter
module tb_iob_ethmac_mem_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] exp_g;

  int n_checks = 0;
  int n_fail   = 0;

  iob_ethmac_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_ethmac_mem_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    bus.m_rdata_i   = 32'hFFFF_FFFF;
    bus.m_ready_i   = 1'b0;

    #2;
    check_eq("rst grant", 64'(grant), 64'h0);
    check_eq("rst busy", 64'(busy), 64'h0);
    check_eq("rst m_valid", 64'(bus.m_valid_o), 64'h0);
    check_eq("rst m_addr", 64'(bus.m_addr_o), 64'h0);
    check_eq("rst m_wdata", 64'(bus.m_wdata_o), 64'h0);
    check_eq("rst m_wstrb", 64'(bus.m_wstrb_o), 64'h0);
    check_eq("rst req_ready", 64'(bus.req_ready_o), 64'h0);
    check_eq("rst req_rdata", 64'(bus.req_rdata_o), 64'h0);
    tick();
    tick();
    arst_n = 1'b1;

    // Single read
    tick();
    bus.req_addr_i[0 +: 32] = 32'h100;
    bus.req_wstrb_i[0 +: 4] = 4'h0;
    bus.req_valid_i         = 2'b01;
    #1;
    check_eq("rd m_valid before edge", 64'(bus.m_valid_o), 64'h0);
    tick();
    check_eq("rd m_valid", 64'(bus.m_valid_o), 64'h1);
    check_eq("rd grant", 64'(grant), 64'h1);
    check_eq("rd m_addr", 64'(bus.m_addr_o), 64'h100);
    check_eq("rd m_wstrb", 64'(bus.m_wstrb_o), 64'h0);
    check_eq("rd busy", 64'(busy), 64'h1);
    check_eq("rd no early ready", 64'(bus.req_ready_o), 64'h0);
    tick();
    tick();
    check_eq("rd m_valid held", 64'(bus.m_valid_o), 64'h1);
    tick();
    bus.m_ready_i = 1'b1;
    bus.m_rdata_i = 32'hCAFE_F00D;
    #1;
    check_eq("rd req_ready", 64'(bus.req_ready_o), 64'h1);
    check_eq("rd req_rdata", 64'(bus.req_rdata_o), 64'hCAFE_F00D);
    tick();
    bus.m_ready_i   = 1'b0;
    bus.req_valid_i = 2'b00;
    #1;
    check_eq("rd idle busy", 64'(busy), 64'h0);
    check_eq("rd idle grant", 64'(grant), 64'h0);
    check_eq("rd idle m_valid", 64'(bus.m_valid_o), 64'h0);
    check_eq("rd idle req_ready", 64'(bus.req_ready_o), 64'h0);
    check_eq("rd idle rdata zero", 64'(bus.req_rdata_o), 64'h0);

    // Simultaneous arrival with pointer at 1, then sustained contention
    bus.req_addr_i[0 +: 32]  = 32'h200;
    bus.req_addr_i[32 +: 32] = 32'h300;
    bus.req_valid_i          = 2'b11;
`ifdef IOB_ETHMAC_ARB_FIXED_PRIO_EN
    exp_g = 2'b01;
`else
    exp_g = 2'b10;
`endif
    tick();
    check_eq("sim first grant", 64'(grant), 64'(exp_g));
    for (int t = 0; t < 4; t++) begin
      #1;
      check_eq("cont grant", 64'(grant), 64'(exp_g));
      check_eq("cont busy", 64'(busy), 64'h1);
      check_eq("cont wait ready", 64'(bus.req_ready_o), 64'h0);
      check_eq("cont m_addr", 64'(bus.m_addr_o), (exp_g == 2'b01) ? 64'h200 : 64'h300);
      tick();
      bus.m_ready_i = 1'b1;
      bus.m_rdata_i = 32'hA0 + 32'(t);
      if (t == 3) bus.req_valid_i = 2'b00;
      #1;
      check_eq("cont owner ready", 64'(bus.req_ready_o), 64'(exp_g));
      check_eq("cont rdata", 64'(bus.req_rdata_o), 64'hA0 + 64'(t));
      tick();
      bus.m_ready_i = 1'b0;
      exp_g = ~exp_g;
    end
    #1;
    check_eq("cont end busy", 64'(busy), 64'h0);
    check_eq("cont end grant", 64'(grant), 64'h0);
    check_eq("cont end m_valid", 64'(bus.m_valid_o), 64'h0);

    // Payload hold after grant
    bus.req_addr_i[0 +: 32]  = 32'h40;
    bus.req_wdata_i[0 +: 32] = 32'h1234_5678;
    bus.req_wstrb_i[0 +: 4]  = 4'hF;
    bus.req_valid_i          = 2'b01;
    tick();
    check_eq("wr grant", 64'(grant), 64'h1);
    check_eq("wr m_wdata", 64'(bus.m_wdata_o), 64'h1234_5678);
    check_eq("wr m_wstrb", 64'(bus.m_wstrb_o), 64'hF);
    check_eq("wr m_addr", 64'(bus.m_addr_o), 64'h40);
    bus.req_wdata_i[0 +: 32] = 32'hDEAD_BEEF;
    bus.req_addr_i[0 +: 32]  = 32'h44;
    bus.req_wstrb_i[0 +: 4]  = 4'h3;
    tick();
    check_eq("hold m_wdata", 64'(bus.m_wdata_o), 64'h1234_5678);
    check_eq("hold m_addr", 64'(bus.m_addr_o), 64'h40);
    check_eq("hold m_wstrb", 64'(bus.m_wstrb_o), 64'hF);
    bus.m_ready_i = 1'b1;
    #1;
    check_eq("wr ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.m_ready_i   = 1'b0;
    bus.req_valid_i = 2'b00;
    #1;
    check_eq("wr idle busy", 64'(busy), 64'h0);

    // Reset in the middle of a transaction
    bus.req_addr_i[32 +: 32] = 32'h300;
    bus.req_wstrb_i[4 +: 4]  = 4'h0;
    bus.req_valid_i          = 2'b10;
    tick();
    check_eq("mid grant", 64'(grant), 64'h2);
    check_eq("mid busy", 64'(busy), 64'h1);
    arst_n        = 1'b0;
    bus.m_ready_i = 1'b1;
    #1;
    check_eq("mid rst m_valid", 64'(bus.m_valid_o), 64'h0);
    check_eq("mid rst grant", 64'(grant), 64'h0);
    check_eq("mid rst busy", 64'(busy), 64'h0);
    check_eq("mid rst no ready", 64'(bus.req_ready_o), 64'h0);
    tick();
    bus.m_ready_i           = 1'b0;
    bus.req_addr_i[0 +: 32] = 32'h200;
    bus.req_wstrb_i[0 +: 4] = 4'h0;
    bus.req_valid_i         = 2'b11;
    arst_n                  = 1'b1;
    tick();
    check_eq("post rst grant", 64'(grant), 64'h1);
    check_eq("post rst m_addr", 64'(bus.m_addr_o), 64'h200);
    bus.m_ready_i   = 1'b1;
    bus.req_valid_i = 2'b00;
    #1;
    check_eq("post rst ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.m_ready_i = 1'b0;
    #1;
    check_eq("post rst idle", 64'(busy), 64'h0);

    // Memory ready while idle is ignored
    bus.m_ready_i = 1'b1;
    #1;
    check_eq("idle stray ready", 64'(bus.req_ready_o), 64'h0);
    tick();
    check_eq("idle stray busy", 64'(busy), 64'h0);
    bus.m_ready_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
